// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcodes, ALU operation codes, control-word bit map.
package mips_pkg;

   localparam int CTRL_W = 10;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;

   // BNE gets its own code so EX can tell the two compare senses apart.
   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_AND = 3'd2;
   localparam logic [2:0] ALU_OR  = 3'd3;
   localparam logic [2:0] ALU_LUI = 3'd4;
   localparam logic [2:0] ALU_SNE = 3'd5;
   localparam logic [2:0] ALU_R   = 3'd7;

   localparam int CTRL_REG_WRITE  = 9;
   localparam int CTRL_MEM_TO_REG = 8;
   localparam int CTRL_MEM_READ   = 7;
   localparam int CTRL_MEM_WRITE  = 6;
   localparam int CTRL_BRANCH     = 5;
   localparam int CTRL_ALU_SRC    = 4;
   localparam int CTRL_REG_DST    = 3;
   localparam int CTRL_ALU_OP_MSB = 2;
   localparam int CTRL_ALU_OP_LSB = 0;

   localparam logic [CTRL_W-1:0] CTRL_NOP = 10'b00_0000_0000;

   typedef enum logic [1:0] {
      IMM_SEXT = 2'd0,
      IMM_ZEXT = 2'd1,
      IMM_LUI  = 2'd2
   } imm_sel_e;

   function automatic logic is_branch_op(input logic [5:0] op);
      return (op == OP_BEQ) || (op == OP_BNE);
   endfunction

endpackage

// File: rtl/id_control_unit.sv
// Combinational opcode decoder: control word, immediate-extension select and rt-as-source flag.
module id_control_unit
   import mips_pkg::*;
(
   input  logic [5:0]        i_opcode,
   output logic [CTRL_W-1:0] o_ctrl,
   output logic [1:0]        o_imm_sel,
   output logic              o_uses_rt
);

   // Opcode to control word; unknown opcodes fall through to a NOP.
   always_comb begin
      o_ctrl    = CTRL_NOP;
      o_imm_sel = IMM_SEXT;
      o_uses_rt = 1'b0;
      case (i_opcode)
         OP_RTYPE: begin
            o_ctrl[CTRL_REG_WRITE] = 1'b1;
            o_ctrl[CTRL_REG_DST]   = 1'b1;
            o_ctrl[CTRL_ALU_OP_MSB:CTRL_ALU_OP_LSB] = ALU_R;
            o_uses_rt = 1'b1;
         end
         OP_LW: begin
            o_ctrl[CTRL_REG_WRITE]  = 1'b1;
            o_ctrl[CTRL_MEM_TO_REG] = 1'b1;
            o_ctrl[CTRL_MEM_READ]   = 1'b1;
            o_ctrl[CTRL_ALU_SRC]    = 1'b1;
            o_ctrl[CTRL_ALU_OP_MSB:CTRL_ALU_OP_LSB] = ALU_ADD;
         end
         OP_SW: begin
            o_ctrl[CTRL_MEM_WRITE] = 1'b1;
            o_ctrl[CTRL_ALU_SRC]   = 1'b1;
            o_ctrl[CTRL_ALU_OP_MSB:CTRL_ALU_OP_LSB] = ALU_ADD;
            o_uses_rt = 1'b1;
         end
         OP_BEQ: begin
            o_ctrl[CTRL_BRANCH] = 1'b1;
            o_ctrl[CTRL_ALU_OP_MSB:CTRL_ALU_OP_LSB] = ALU_SUB;
            o_uses_rt = 1'b1;
         end
         OP_BNE: begin
            o_ctrl[CTRL_BRANCH] = 1'b1;
            o_ctrl[CTRL_ALU_OP_MSB:CTRL_ALU_OP_LSB] = ALU_SNE;
            o_uses_rt = 1'b1;
         end
         OP_ADDI: begin
            o_ctrl[CTRL_REG_WRITE] = 1'b1;
            o_ctrl[CTRL_ALU_SRC]   = 1'b1;
            o_ctrl[CTRL_ALU_OP_MSB:CTRL_ALU_OP_LSB] = ALU_ADD;
         end
         OP_ANDI: begin
            o_ctrl[CTRL_REG_WRITE] = 1'b1;
            o_ctrl[CTRL_ALU_SRC]   = 1'b1;
            o_ctrl[CTRL_ALU_OP_MSB:CTRL_ALU_OP_LSB] = ALU_AND;
            o_imm_sel = IMM_ZEXT;
         end
         OP_ORI: begin
            o_ctrl[CTRL_REG_WRITE] = 1'b1;
            o_ctrl[CTRL_ALU_SRC]   = 1'b1;
            o_ctrl[CTRL_ALU_OP_MSB:CTRL_ALU_OP_LSB] = ALU_OR;
            o_imm_sel = IMM_ZEXT;
         end
         OP_LUI: begin
            o_ctrl[CTRL_REG_WRITE] = 1'b1;
            o_ctrl[CTRL_ALU_SRC]   = 1'b1;
            o_ctrl[CTRL_ALU_OP_MSB:CTRL_ALU_OP_LSB] = ALU_LUI;
            o_imm_sel = IMM_LUI;
         end
         default: begin
            o_ctrl    = CTRL_NOP;
            o_imm_sel = IMM_SEXT;
            o_uses_rt = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/id_decode_stage.sv
// MIPS ID stage: register-file addressing, control decode, load-use hazard and the ID/EX register.
// Optional ID_BRANCH_RESOLVE_EN resolves BEQ/BNE here and adds o_branch_taken/o_branch_target.
module id_decode_stage
   import mips_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int INSTR_WIDTH = 32,
   parameter int P_REG_WIDTH = 5,
   parameter int CTRL_WIDTH  = 10
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic [INSTR_WIDTH-1:0] i_instr,
   input  logic [DATA_WIDTH-1:0]  i_pc_plus4,
   input  logic                   i_valid,
   input  logic                   i_flush,
   input  logic [DATA_WIDTH-1:0]  i_rs_data,
   input  logic [DATA_WIDTH-1:0]  i_rt_data,
   input  logic                   i_ex_mem_read,
   input  logic [P_REG_WIDTH-1:0] i_ex_rt,
   output logic [P_REG_WIDTH-1:0] o_rs_addr,
   output logic [P_REG_WIDTH-1:0] o_rt_addr,
   output logic                   o_stall,
   output logic                   o_valid,
   output logic [CTRL_WIDTH-1:0]  o_ctrl,
   output logic [DATA_WIDTH-1:0]  o_rs_val,
   output logic [DATA_WIDTH-1:0]  o_rt_val,
   output logic [DATA_WIDTH-1:0]  o_imm,
   output logic [P_REG_WIDTH-1:0] o_rs,
   output logic [P_REG_WIDTH-1:0] o_rt,
   output logic [P_REG_WIDTH-1:0] o_rd,
   output logic [DATA_WIDTH-1:0]  o_pc_plus4
`ifdef ID_BRANCH_RESOLVE_EN
   ,
   output logic                   o_branch_taken,
   output logic [DATA_WIDTH-1:0]  o_branch_target
`endif
);

   logic [5:0]             opcode;
   logic [P_REG_WIDTH-1:0] rs_f, rt_f, rd_f;
   logic [15:0]            imm16;
   logic [CTRL_W-1:0]      ctrl_raw;
   logic [CTRL_WIDTH-1:0]  ctrl_dec;
   logic [1:0]             imm_sel;
   logic                   uses_rt;
   logic [DATA_WIDTH-1:0]  sext_imm, imm_ext;
   logic                   hazard, load;

   logic                   valid_d, valid_q;
   logic [CTRL_WIDTH-1:0]  ctrl_d, ctrl_q;
   logic [DATA_WIDTH-1:0]  rs_val_d, rs_val_q, rt_val_d, rt_val_q;
   logic [DATA_WIDTH-1:0]  imm_d, imm_q, pc_plus4_d, pc_plus4_q;
   logic [P_REG_WIDTH-1:0] rs_d, rs_q, rt_d, rt_q, rd_d, rd_q;

   assign opcode = i_instr[31:26];
   assign rs_f   = i_instr[25:21];
   assign rt_f   = i_instr[20:16];
   assign rd_f   = i_instr[15:11];
   assign imm16  = i_instr[15:0];

   assign o_rs_addr = rs_f;
   assign o_rt_addr = rt_f;

   id_control_unit u_ctrl (
      .i_opcode  (opcode),
      .o_ctrl    (ctrl_raw),
      .o_imm_sel (imm_sel),
      .o_uses_rt (uses_rt)
   );

   assign sext_imm = DATA_WIDTH'($signed(imm16));

   // Immediate extension selected by the decoder.
   always_comb begin
      imm_ext = sext_imm;
      case (imm_sel)
         IMM_SEXT: imm_ext = sext_imm;
         IMM_ZEXT: imm_ext = DATA_WIDTH'(imm16);
         IMM_LUI:  imm_ext = DATA_WIDTH'({imm16, 16'h0000});
         default:  imm_ext = sext_imm;
      endcase
   end

   // Load-use hazard; $0 is hard-wired zero so a load into it never conflicts.
   always_comb begin
      hazard = 1'b0;
      if (i_valid && i_ex_mem_read && (i_ex_rt != '0)) begin
         hazard = (i_ex_rt == rs_f) || (uses_rt && (i_ex_rt == rt_f));
      end else begin
         hazard = 1'b0;
      end
   end

   assign o_stall = hazard & ~i_flush;

`ifdef ID_BRANCH_RESOLVE_EN
   logic ops_equal, is_beq, is_bne;
   assign is_beq    = (opcode == OP_BEQ);
   assign is_bne    = (opcode == OP_BNE);
   assign ops_equal = (i_rs_data == i_rt_data);
   assign o_branch_taken  = i_valid & ~o_stall & ((is_beq & ops_equal) | (is_bne & ~ops_equal));
   assign o_branch_target = i_pc_plus4 + (sext_imm << 2);

   // Branches are finished here, so EX must not see a branch request.
   always_comb begin
      ctrl_dec = CTRL_WIDTH'(ctrl_raw);
      if (is_branch_op(opcode)) begin
         ctrl_dec[CTRL_BRANCH] = 1'b0;
      end else begin
         ctrl_dec[CTRL_BRANCH] = ctrl_raw[CTRL_BRANCH];
      end
   end
`else
   assign ctrl_dec = CTRL_WIDTH'(ctrl_raw);
`endif

   assign load = i_valid & ~i_flush & ~hazard;

   // ID/EX next state: reset, load, or bubble that holds the data fields.
   always_comb begin
      valid_d    = valid_q;
      ctrl_d     = ctrl_q;
      rs_val_d   = rs_val_q;
      rt_val_d   = rt_val_q;
      imm_d      = imm_q;
      rs_d       = rs_q;
      rt_d       = rt_q;
      rd_d       = rd_q;
      pc_plus4_d = pc_plus4_q;
      if (i_reset) begin
         valid_d    = 1'b0;
         ctrl_d     = '0;
         rs_val_d   = '0;
         rt_val_d   = '0;
         imm_d      = '0;
         rs_d       = '0;
         rt_d       = '0;
         rd_d       = '0;
         pc_plus4_d = '0;
      end else if (load) begin
         valid_d    = 1'b1;
         ctrl_d     = ctrl_dec;
         rs_val_d   = i_rs_data;
         rt_val_d   = i_rt_data;
         imm_d      = imm_ext;
         rs_d       = rs_f;
         rt_d       = rt_f;
         rd_d       = rd_f;
         pc_plus4_d = i_pc_plus4;
      end else begin
         valid_d = 1'b0;
         ctrl_d  = '0;
      end
   end

   // ID/EX pipeline register.
   always_ff @(posedge i_clk) begin
      valid_q    <= valid_d;
      ctrl_q     <= ctrl_d;
      rs_val_q   <= rs_val_d;
      rt_val_q   <= rt_val_d;
      imm_q      <= imm_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      rd_q       <= rd_d;
      pc_plus4_q <= pc_plus4_d;
   end

   assign o_valid    = valid_q;
   assign o_ctrl     = ctrl_q;
   assign o_rs_val   = rs_val_q;
   assign o_rt_val   = rt_val_q;
   assign o_imm      = imm_q;
   assign o_rs       = rs_q;
   assign o_rt       = rt_q;
   assign o_rd       = rd_q;
   assign o_pc_plus4 = pc_plus4_q;

endmodule

// File: tb/tb_id_decode_stage.sv
// Self-checking bench for id_decode_stage: directed scenarios plus randomized traffic vs. a behavioural model.
module tb_id_decode_stage;
   import mips_pkg::*;

   logic        i_clk = 1'b0;
   logic        i_reset, i_valid, i_flush, i_ex_mem_read;
   logic [31:0] i_instr, i_pc_plus4, i_rs_data, i_rt_data;
   logic [4:0]  i_ex_rt;
   logic [4:0]  o_rs_addr, o_rt_addr, o_rs, o_rt, o_rd;
   logic        o_stall, o_valid;
   logic [9:0]  o_ctrl;
   logic [31:0] o_rs_val, o_rt_val, o_imm, o_pc_plus4;
`ifdef ID_BRANCH_RESOLVE_EN
   logic        o_branch_taken;
   logic [31:0] o_branch_target;
`endif

   always #5 i_clk = ~i_clk;

   id_decode_stage dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_instr(i_instr), .i_pc_plus4(i_pc_plus4),
      .i_valid(i_valid), .i_flush(i_flush), .i_rs_data(i_rs_data), .i_rt_data(i_rt_data),
      .i_ex_mem_read(i_ex_mem_read), .i_ex_rt(i_ex_rt),
      .o_rs_addr(o_rs_addr), .o_rt_addr(o_rt_addr), .o_stall(o_stall), .o_valid(o_valid),
      .o_ctrl(o_ctrl), .o_rs_val(o_rs_val), .o_rt_val(o_rt_val), .o_imm(o_imm),
      .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd), .o_pc_plus4(o_pc_plus4)
`ifdef ID_BRANCH_RESOLVE_EN
      , .o_branch_taken(o_branch_taken), .o_branch_target(o_branch_target)
`endif
   );

   int total = 0;
   int bad   = 0;

   // expected ID/EX contents
   logic        e_valid, e_imm_known;
   logic [9:0]  e_ctrl;
   logic [31:0] e_rs_val, e_rt_val, e_imm, e_pc;
   logic [4:0]  e_rs, e_rt, e_rd;

   // control word {reg_write, mem_to_reg, mem_read, mem_write, branch, alu_src, reg_dst, alu_op}
   function automatic logic [9:0] m_ctrl(input logic [31:0] ins);
      logic rw, mtr, mr, mw, br, as, rdst;
      logic [2:0] aop;
      {rw, mtr, mr, mw, br, as, rdst} = 7'b0;
      aop = 3'b000;
      case (ins[31:26])
         6'h00: begin rw = 1'b1; rdst = 1'b1; aop = ALU_R; end
         6'h23: begin rw = 1'b1; mtr = 1'b1; mr = 1'b1; as = 1'b1; aop = ALU_ADD; end
         6'h2B: begin mw = 1'b1; as = 1'b1; aop = ALU_ADD; end
         6'h04: begin br = 1'b1; aop = ALU_SUB; end
         6'h05: begin br = 1'b1; aop = ALU_SNE; end
         6'h08: begin rw = 1'b1; as = 1'b1; aop = ALU_ADD; end
         6'h0C: begin rw = 1'b1; as = 1'b1; aop = ALU_AND; end
         6'h0D: begin rw = 1'b1; as = 1'b1; aop = ALU_OR; end
         6'h0F: begin rw = 1'b1; as = 1'b1; aop = ALU_LUI; end
         default: aop = 3'b000;
      endcase
`ifdef ID_BRANCH_RESOLVE_EN
      br = 1'b0;
`endif
      return {rw, mtr, mr, mw, br, as, rdst, aop};
   endfunction

   function automatic logic m_uses_rt(input logic [31:0] ins);
      return ins[31:26] inside {6'h00, 6'h2B, 6'h04, 6'h05};
   endfunction

   function automatic logic m_imm_known(input logic [31:0] ins);
      return ins[31:26] inside {6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h0F};
   endfunction

   function automatic logic [31:0] m_imm(input logic [31:0] ins);
      logic [15:0] lo;
      lo = ins[15:0];
      if (ins[31:26] inside {6'h0C, 6'h0D}) return 32'(lo);
      else if (ins[31:26] == 6'h0F) return 32'(lo) * 32'd65536;
      else return 32'($signed(lo));
   endfunction

   function automatic logic m_stall();
      logic [4:0] rs, rt;
      rs = i_instr[25:21];
      rt = i_instr[20:16];
      if (!i_valid || !i_ex_mem_read || i_ex_rt == 5'd0 || i_flush) return 1'b0;
      return (i_ex_rt == rs) || (m_uses_rt(i_instr) && i_ex_rt == rt);
   endfunction

   // one posedge: advance the model from the inputs present at the edge
   task automatic do_clock();
      logic st;
      st = m_stall();
      @(posedge i_clk);
      if (i_reset) begin
         e_valid = 1'b0; e_ctrl = 10'd0; e_rs_val = 32'd0; e_rt_val = 32'd0;
         e_imm = 32'd0; e_imm_known = 1'b1; e_pc = 32'd0;
         e_rs = 5'd0; e_rt = 5'd0; e_rd = 5'd0;
      end else if (i_flush || st || !i_valid) begin
         e_valid = 1'b0; e_ctrl = 10'd0;
      end else begin
         e_valid = 1'b1; e_ctrl = m_ctrl(i_instr);
         e_rs_val = i_rs_data; e_rt_val = i_rt_data; e_pc = i_pc_plus4;
         e_imm = m_imm(i_instr); e_imm_known = m_imm_known(i_instr);
         e_rs = i_instr[25:21]; e_rt = i_instr[20:16]; e_rd = i_instr[15:11];
      end
      #1;
   endtask

   task automatic test_reset();
      i_reset = 1'b1; i_valid = 1'b1; i_instr = 32'h2022FFFC; i_rs_data = 32'd10;
      i_pc_plus4 = 32'h100;
      do_clock();
      total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %h want 0", o_valid); end
      total++; if (o_ctrl !== 10'd0) begin bad++; $display("FAIL reset_ctrl got %h want 0", o_ctrl); end
      total++; if ({o_rs_val, o_rt_val, o_imm, o_pc_plus4, o_rs, o_rt, o_rd} !== 143'd0) begin
         bad++; $display("FAIL reset_data got %h %h %h %h want all 0", o_rs_val, o_imm, o_pc_plus4, o_rd); end
      i_reset = 1'b0;
      do_clock();
      total++; if (o_valid !== 1'b1 || o_ctrl !== 10'h210) begin
         bad++; $display("FAIL reset_release got v=%h ctrl=%h want v=1 ctrl=210", o_valid, o_ctrl); end
   endtask

   task automatic test_addi();
      i_instr = 32'h2022FFFC; i_rs_data = 32'd10; i_rt_data = 32'd77; i_valid = 1'b1;
      i_pc_plus4 = 32'h204; i_ex_mem_read = 1'b0; i_ex_rt = 5'd0;
      #1;
      total++; if (o_rs_addr !== 5'd1 || o_rt_addr !== 5'd2) begin
         bad++; $display("FAIL addi_addr got %0d,%0d want 1,2", o_rs_addr, o_rt_addr); end
      do_clock();
      total++; if (o_rs !== 5'd1 || o_rt !== 5'd2) begin
         bad++; $display("FAIL addi_fields got rs=%0d rt=%0d want 1,2", o_rs, o_rt); end
      total++; if (o_imm !== 32'hFFFFFFFC) begin bad++; $display("FAIL addi_imm got %h want fffffffc", o_imm); end
      total++; if (o_rs_val !== 32'd10 || o_pc_plus4 !== 32'h204) begin
         bad++; $display("FAIL addi_data got %h/%h want a/204", o_rs_val, o_pc_plus4); end
      total++; if (o_ctrl[4] !== 1'b1 || o_ctrl[9] !== 1'b1 || o_ctrl[3] !== 1'b0) begin
         bad++; $display("FAIL addi_ctrl got %h want alu_src=1 reg_write=1 reg_dst=0", o_ctrl); end
   endtask

   task automatic test_load_use();
      logic [31:0] held;
      held = o_imm;
      i_instr = 32'h00652020; i_ex_mem_read = 1'b1; i_ex_rt = 5'd3; i_valid = 1'b1;
      i_rs_data = 32'h11; i_rt_data = 32'h22;
      #1;
      total++; if (o_stall !== 1'b1) begin bad++; $display("FAIL lu_stall got %h want 1", o_stall); end
      do_clock();
      total++; if (o_valid !== 1'b0 || o_ctrl !== 10'd0 || o_imm !== held) begin
         bad++; $display("FAIL lu_bubble got v=%h ctrl=%h imm=%h want 0/0/%h", o_valid, o_ctrl, o_imm, held); end
      i_ex_mem_read = 1'b0;
      #1;
      total++; if (o_stall !== 1'b0) begin bad++; $display("FAIL lu_clear got %h want 0", o_stall); end
      do_clock();
      total++; if (o_valid !== 1'b1 || o_ctrl !== 10'h20F || o_rd !== 5'd4 || o_rs !== 5'd3 || o_rt !== 5'd5) begin
         bad++; $display("FAIL lu_latch got v=%h ctrl=%h rd=%0d want 1/20f/4", o_valid, o_ctrl, o_rd); end
      i_ex_mem_read = 1'b1; i_ex_rt = 5'd5;
      #1;
      total++; if (o_stall !== 1'b1) begin bad++; $display("FAIL lu_rt_stall got %h want 1", o_stall); end
      i_ex_mem_read = 1'b0;
   endtask

   task automatic test_exemptions();
      i_instr = 32'h00052020; i_ex_mem_read = 1'b1; i_ex_rt = 5'd0; i_valid = 1'b1;
      #1;
      total++; if (o_stall !== 1'b0) begin bad++; $display("FAIL ex_zero got %h want 0", o_stall); end
      i_instr = 32'h2022FFFC; i_ex_rt = 5'd2;
      #1;
      total++; if (o_stall !== 1'b0) begin bad++; $display("FAIL ex_addi_rt got %h want 0", o_stall); end
      i_ex_rt = 5'd1;
      #1;
      total++; if (o_stall !== 1'b1) begin bad++; $display("FAIL ex_addi_rs got %h want 1", o_stall); end
      i_valid = 1'b0;
      #1;
      total++; if (o_stall !== 1'b0) begin bad++; $display("FAIL ex_invalid got %h want 0", o_stall); end
      i_valid = 1'b1; i_ex_mem_read = 1'b0;
      do_clock();
   endtask

   task automatic test_flush();
      i_instr = 32'h00652020; i_ex_mem_read = 1'b1; i_ex_rt = 5'd3; i_valid = 1'b1; i_flush = 1'b1;
      #1;
      total++; if (o_stall !== 1'b0) begin bad++; $display("FAIL flush_stall got %h want 0", o_stall); end
      do_clock();
      total++; if (o_valid !== 1'b0 || o_ctrl !== 10'd0) begin
         bad++; $display("FAIL flush_bubble got v=%h ctrl=%h want 0/0", o_valid, o_ctrl); end
      i_flush = 1'b0; i_ex_mem_read = 1'b0;
   endtask

   // chain of dependent loads; EX-stage load info is fed back from the ID/EX outputs
   task automatic test_back_to_back();
      logic [31:0] seq [4];
      int exp_st [4];
      int st_cnt, cycles;
      seq = '{32'h8C010000, 32'h8C230000, 32'h8C650000, 32'h00A02020};
      exp_st = '{0, 1, 1, 1};
      i_flush = 1'b1; i_valid = 1'b1; i_ex_mem_read = 1'b0;
      do_clock();
      i_flush = 1'b0;
      cycles = 0;
      for (int k = 0; k < 4; k++) begin
         st_cnt = 0;
         i_instr = seq[k];
         for (int c = 0; c < 4; c++) begin
            i_ex_mem_read = o_valid & o_ctrl[7];
            i_ex_rt = o_rt;
            #1;
            cycles++;
            if (o_stall === 1'b1) begin
               st_cnt++;
               do_clock();
            end else begin
               do_clock();
               break;
            end
         end
         total++; if (st_cnt != exp_st[k]) begin
            bad++; $display("FAIL b2b_stalls[%0d] got %0d want %0d", k, st_cnt, exp_st[k]); end
      end
      total++; if (cycles != 7) begin bad++; $display("FAIL b2b_cycles got %0d want 7", cycles); end
      total++; if (o_valid !== 1'b1 || o_rs !== 5'd5 || o_ctrl !== 10'h20F) begin
         bad++; $display("FAIL b2b_last got v=%h rs=%0d ctrl=%h want 1/5/20f", o_valid, o_rs, o_ctrl); end
      i_ex_mem_read = 1'b0;
   endtask

`ifdef ID_BRANCH_RESOLVE_EN
   task automatic test_branch();
      i_instr = 32'h10220003; i_pc_plus4 = 32'h40; i_rs_data = 32'd7; i_rt_data = 32'd7;
      i_valid = 1'b1; i_ex_mem_read = 1'b0; i_flush = 1'b0;
      #1;
      total++; if (o_branch_taken !== 1'b1 || o_branch_target !== 32'h4C) begin
         bad++; $display("FAIL br_eq got t=%h tgt=%h want 1/4c", o_branch_taken, o_branch_target); end
      i_rt_data = 32'd8;
      #1;
      total++; if (o_branch_taken !== 1'b0) begin bad++; $display("FAIL br_ne got %h want 0", o_branch_taken); end
      do_clock();
      total++; if (o_ctrl[5] !== 1'b0 || o_valid !== 1'b1) begin
         bad++; $display("FAIL br_ctrl got ctrl=%h v=%h want branch bit 0", o_ctrl, o_valid); end
   endtask
`endif

   task automatic test_random();
      logic [5:0] ops [11];
      logic [31:0] ins;
      logic est;
      ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h02, 6'h3F};
      for (int n = 0; n < 400; n++) begin
         ins = {ops[$urandom_range(10, 0)], 5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)),
                5'($urandom_range(31, 0)), 11'($urandom)};
         i_instr = ins;
         i_reset = ($urandom_range(60, 0) == 0);
         i_valid = ($urandom_range(9, 0) < 8);
         i_flush = ($urandom_range(9, 0) == 0);
         i_ex_mem_read = $urandom_range(1, 0);
         i_ex_rt = 5'($urandom_range(7, 0));
         i_rs_data = $urandom;
         i_rt_data = ($urandom_range(3, 0) == 0) ? i_rs_data : $urandom;
         i_pc_plus4 = {$urandom, 2'b00};
         #1;
         est = m_stall();
         total++; if (o_stall !== est) begin bad++; $display("FAIL rnd_stall n=%0d got %h want %h", n, o_stall, est); end
         total++; if (o_rs_addr !== ins[25:21] || o_rt_addr !== ins[20:16]) begin
            bad++; $display("FAIL rnd_addr n=%0d got %0d,%0d", n, o_rs_addr, o_rt_addr); end
`ifdef ID_BRANCH_RESOLVE_EN
         total++;
         if (o_branch_taken !== (i_valid && !est &&
             ((ins[31:26] == 6'h04 && i_rs_data == i_rt_data) || (ins[31:26] == 6'h05 && i_rs_data != i_rt_data)))
             || o_branch_target !== i_pc_plus4 + 32'($signed(ins[15:0])) * 32'd4) begin
            bad++; $display("FAIL rnd_branch n=%0d got %h/%h", n, o_branch_taken, o_branch_target); end
`endif
         do_clock();
         total++; if (o_valid !== e_valid || o_ctrl !== e_ctrl) begin
            bad++; $display("FAIL rnd_ctrl n=%0d got %h/%h want %h/%h", n, o_valid, o_ctrl, e_valid, e_ctrl); end
         total++; if (o_rs_val !== e_rs_val || o_rt_val !== e_rt_val || o_pc_plus4 !== e_pc) begin
            bad++; $display("FAIL rnd_data n=%0d got %h %h %h want %h %h %h", n, o_rs_val, o_rt_val,
                            o_pc_plus4, e_rs_val, e_rt_val, e_pc); end
         total++; if (o_rs !== e_rs || o_rt !== e_rt || o_rd !== e_rd) begin
            bad++; $display("FAIL rnd_fields n=%0d got %0d %0d %0d want %0d %0d %0d", n, o_rs, o_rt, o_rd,
                            e_rs, e_rt, e_rd); end
         if (e_imm_known) begin
            total++; if (o_imm !== e_imm) begin
               bad++; $display("FAIL rnd_imm n=%0d got %h want %h", n, o_imm, e_imm); end
         end
      end
      i_reset = 1'b0; i_flush = 1'b0; i_ex_mem_read = 1'b0;
   endtask

   initial begin
      i_reset = 1'b1; i_valid = 1'b0; i_flush = 1'b0; i_ex_mem_read = 1'b0; i_ex_rt = 5'd0;
      i_instr = 32'd0; i_pc_plus4 = 32'd0; i_rs_data = 32'd0; i_rt_data = 32'd0;
      test_reset();
      test_addi();
      test_load_use();
      test_exemptions();
      test_flush();
      test_back_to_back();
`ifdef ID_BRANCH_RESOLVE_EN
      test_branch();
`endif
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
